// File: rtl/vx_sched_chk_pkg.sv
// Shared types and constants for the warp-scheduler runtime checker.
package vx_sched_chk_pkg;

  localparam int unsigned ERR_W     = 3;
  localparam int unsigned NUM_CODES = 8;

  typedef enum logic [ERR_W-1:0] {
    ERR_STALL_TO     = 3'd0,
    ERR_BAR_DUP      = 3'd1,
    ERR_BAR_SIZE     = 3'd2,
    ERR_BAR_ESCAPE   = 3'd3,
    ERR_WSPAWN       = 3'd4,
    ERR_GBAR_NOREQ   = 3'd5,
    ERR_GBAR_ID      = 3'd6,
    ERR_GBAR_TO_SPUR = 3'd7
  } err_code_e;

  typedef enum logic [1:0] {
    GBAR_IDLE     = 2'd0,
    GBAR_WAIT_REQ = 2'd1,
    GBAR_WAIT_RSP = 2'd2
  } gbar_state_e;

endpackage

// File: rtl/vx_sched_bar_track.sv
// One local barrier: arrived mask, arrival count, latched size, and the
// duplicate / size-mismatch / escape detection for that barrier id.
module vx_sched_bar_track #(
  parameter  int unsigned NUM_WARPS = 4,
  localparam int unsigned NW_W      = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arrive_i,
  input  logic [NW_W-1:0]      wid_i,
  input  logic [NW_W-1:0]      size_m1_i,
  input  logic [NUM_WARPS-1:0] stalled_i,
  output logic                 dup_c_o,
  output logic                 size_err_c_o,
  output logic                 escape_c_o,
  output logic [NW_W-1:0]      escape_wid_c_o
);

  logic [NUM_WARPS-1:0] mask_q, mask_d;
  logic [NW_W-1:0]      cnt_q, cnt_d;
  logic [NW_W-1:0]      size_q, size_d;
  logic [NW_W-1:0]      eff_size;
  logic [NUM_WARPS-1:0] esc_mask;
  logic                 release_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      cnt_q  <= '0;
      size_q <= '0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      size_q <= size_d;
    end
  end

  // The first arrival defines the size; a release empties the barrier next edge.
  always_comb begin
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    dup_c_o      = arrive_i & mask_q[wid_i];
    eff_size     = (cnt_q == '0) ? size_m1_i : size_q;
    release_c    = arrive_i & ~dup_c_o & (cnt_q == eff_size);
    size_err_c_o = arrive_i & (cnt_q != '0) & (size_m1_i != size_q);
    if (arrive_i & ~dup_c_o) begin
      if (release_c) begin
        mask_d = '0;
        cnt_d  = '0;
      end else begin
        mask_d[wid_i] = 1'b1;
        cnt_d         = cnt_q + NW_W'(1);
        if (cnt_q == '0) size_d = size_m1_i;
      end
    end
  end

  // A releasing barrier never reports an escape in its release cycle.
  always_comb begin
    esc_mask       = mask_q & ~stalled_i;
    escape_c_o     = (|esc_mask) & ~release_c;
    escape_wid_c_o = '0;
    for (int w = NUM_WARPS - 1; w >= 0; w--) begin
      if (esc_mask[w]) escape_wid_c_o = NW_W'(w);
    end
  end

endmodule

// File: rtl/vx_sched_checker.sv
// Runtime checker beside the warp scheduler: stall watchdogs, local barrier
// accounting, wspawn legality and global-barrier pairing, with one reported error per cycle.
module vx_sched_checker
  import vx_sched_chk_pkg::*;
#(
  parameter  int unsigned NUM_WARPS    = 4,
  parameter  int unsigned NUM_BARRIERS = 4,
  parameter  int unsigned TIMEOUT_W    = 16,
  parameter  bit          GBAR_EN      = 1'b1,
  localparam int unsigned NW_W         = $clog2(NUM_WARPS),
  localparam int unsigned NB_W         = $clog2(NUM_BARRIERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic                 clear,
  input  logic                 ctl_valid,
  input  logic [NW_W-1:0]      ctl_wid,
  input  logic                 bar_valid,
  input  logic                 bar_is_global,
  input  logic                 bar_is_noop,
  input  logic [NB_W-1:0]      bar_id,
  input  logic [NW_W-1:0]      bar_size_m1,
  input  logic                 wspawn_valid,
  input  logic [NUM_WARPS-1:0] active_warps,
  input  logic [NUM_WARPS-1:0] stalled_warps,
  input  logic                 gbar_req_valid,
  input  logic                 gbar_rsp_valid,
  input  logic [NB_W-1:0]      gbar_req_id,
  input  logic [NB_W-1:0]      gbar_rsp_id,
  output logic                 err_valid,
  output logic [ERR_W-1:0]     err_code,
  output logic [NW_W-1:0]      err_wid,
  output logic [NB_W-1:0]      err_bar,
  output logic [7:0]           err_status,
  output logic [7:0]           err_count
);

  logic [TIMEOUT_W-1:0]    stall_cnt_q [NUM_WARPS];
  logic [TIMEOUT_W-1:0]    stall_cnt_d [NUM_WARPS];
  logic [NUM_WARPS-1:0]    stall_hit;
  logic                    local_arrive;
  logic [NUM_BARRIERS-1:0] bar_dup, bar_size_err, bar_esc;
  logic [NW_W-1:0]         bar_esc_wid [NUM_BARRIERS];
  logic                    wspawn_err;
  logic [2:0]              gbar_err;
  logic [NB_W-1:0]         gbar_bar, spur_bar;
  logic [NW_W-1:0]         gbar_wid, spur_wid;
  logic [NUM_CODES-1:0]    err_det;
  logic [NW_W-1:0]         stall_wid;
  logic [NB_W-1:0]         esc_bar;
  logic                    unused_gbar;

  logic                 err_valid_q, err_valid_d;
  err_code_e            err_code_q, err_code_d;
  logic [NW_W-1:0]      err_wid_q, err_wid_d;
  logic [NB_W-1:0]      err_bar_q, err_bar_d;
  logic [7:0]           err_status_q, err_status_d;
  logic [7:0]           err_count_q, err_count_d;

  // The request id carries no check of its own; only the response id is compared.
  assign unused_gbar = ^{gbar_req_id, gbar_req_valid, gbar_rsp_valid, gbar_rsp_id, bar_is_noop};

  // Watchdog counts stalled cycles, fires once on reaching the limit, then holds.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      stall_cnt_d[w] = '0;
      stall_hit[w]   = 1'b0;
      if (stalled_warps[w]) begin
        stall_cnt_d[w] = stall_cnt_q[w];
        if (stall_cnt_q[w] < cfg_timeout) begin
          stall_cnt_d[w] = stall_cnt_q[w] + TIMEOUT_W'(1);
          stall_hit[w]   = ((stall_cnt_q[w] + TIMEOUT_W'(1)) == cfg_timeout);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) stall_cnt_q[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) stall_cnt_q[w] <= stall_cnt_d[w];
    end
  end

  assign local_arrive = ctl_valid & bar_valid & ~bar_is_global;

  for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_bar
    vx_sched_bar_track #(.NUM_WARPS(NUM_WARPS)) u_track (
      .clk            (clk),
      .reset          (reset),
      .arrive_i       (local_arrive & (bar_id == NB_W'(b))),
      .wid_i          (ctl_wid),
      .size_m1_i      (bar_size_m1),
      .stalled_i      (stalled_warps),
      .dup_c_o        (bar_dup[b]),
      .size_err_c_o   (bar_size_err[b]),
      .escape_c_o     (bar_esc[b]),
      .escape_wid_c_o (bar_esc_wid[b])
    );
  end

  assign wspawn_err = ctl_valid & wspawn_valid & ($countones(active_warps) != 1);

  if (GBAR_EN) begin : g_gbar
    gbar_state_e          state_q, state_d;
    logic [NB_W-1:0]      gid_q, gid_d;
    logic [NW_W-1:0]      gwid_q, gwid_d;
    logic [TIMEOUT_W-1:0] gtimer_q, gtimer_d;
    logic                 noop_c;
    logic                 timeout_c;

    assign noop_c    = ctl_valid & bar_valid & bar_is_global & bar_is_noop;
    assign timeout_c = (cfg_timeout != '0) &&
                       (({1'b0, gtimer_q} + (TIMEOUT_W+1)'(1)) >= {1'b0, cfg_timeout});

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= GBAR_IDLE;
        gid_q    <= '0;
        gwid_q   <= '0;
        gtimer_q <= '0;
      end else begin
        state_q  <= state_d;
        gid_q    <= gid_d;
        gwid_q   <= gwid_d;
        gtimer_q <= gtimer_d;
      end
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        GBAR_IDLE:     if (noop_c) state_d = GBAR_WAIT_REQ;
        GBAR_WAIT_REQ: state_d = gbar_req_valid ? GBAR_WAIT_RSP : GBAR_IDLE;
        GBAR_WAIT_RSP: if (gbar_rsp_valid || timeout_c) state_d = GBAR_IDLE;
        default:       state_d = GBAR_IDLE;
      endcase
    end

    // gbar_err bits map to codes 5..7; code 7 carries its own context.
    always_comb begin
      gid_d    = gid_q;
      gwid_d   = gwid_q;
      gtimer_d = gtimer_q;
      gbar_err = '0;
      gbar_bar = gid_q;
      gbar_wid = gwid_q;
      spur_bar = gbar_rsp_id;
      spur_wid = '0;
      case (state_q)
        GBAR_IDLE: begin
          gbar_err[2] = gbar_rsp_valid;
          if (noop_c) begin
            gid_d  = bar_id;
            gwid_d = ctl_wid;
          end
        end
        GBAR_WAIT_REQ: begin
          gbar_err[2] = gbar_rsp_valid;
          gbar_err[0] = ~gbar_req_valid;
          if (gbar_req_valid) gtimer_d = '0;
        end
        GBAR_WAIT_RSP: begin
          spur_bar = gid_q;
          spur_wid = gwid_q;
          if (gbar_rsp_valid) begin
            gbar_err[1] = (gbar_rsp_id != gid_q);
          end else begin
            gbar_err[2] = timeout_c;
            if (!timeout_c && cfg_timeout != '0) gtimer_d = gtimer_q + TIMEOUT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end else begin : g_no_gbar
    assign gbar_err = '0;
    assign gbar_bar = '0;
    assign gbar_wid = '0;
    assign spur_bar = '0;
    assign spur_wid = '0;
  end

  // Lowest code wins; every detected code lands in the sticky status.
  always_comb begin
    err_det   = {gbar_err, wspawn_err, |bar_esc, |bar_size_err, |bar_dup, |stall_hit};
    stall_wid = '0;
    for (int w = NUM_WARPS - 1; w >= 0; w--) begin
      if (stall_hit[w]) stall_wid = NW_W'(w);
    end
    esc_bar = '0;
    for (int b = NUM_BARRIERS - 1; b >= 0; b--) begin
      if (bar_esc[b]) esc_bar = NB_W'(b);
    end
    err_valid_d = |err_det;
    err_code_d  = err_code_q;
    err_wid_d   = err_wid_q;
    err_bar_d   = err_bar_q;
    if (err_det[0]) begin
      err_code_d = ERR_STALL_TO;     err_wid_d = stall_wid;          err_bar_d = '0;
    end else if (err_det[1]) begin
      err_code_d = ERR_BAR_DUP;      err_wid_d = ctl_wid;            err_bar_d = bar_id;
    end else if (err_det[2]) begin
      err_code_d = ERR_BAR_SIZE;     err_wid_d = ctl_wid;            err_bar_d = bar_id;
    end else if (err_det[3]) begin
      err_code_d = ERR_BAR_ESCAPE;   err_wid_d = bar_esc_wid[esc_bar]; err_bar_d = esc_bar;
    end else if (err_det[4]) begin
      err_code_d = ERR_WSPAWN;       err_wid_d = ctl_wid;            err_bar_d = '0;
    end else if (err_det[5]) begin
      err_code_d = ERR_GBAR_NOREQ;   err_wid_d = gbar_wid;           err_bar_d = gbar_bar;
    end else if (err_det[6]) begin
      err_code_d = ERR_GBAR_ID;      err_wid_d = gbar_wid;           err_bar_d = gbar_bar;
    end else if (err_det[7]) begin
      err_code_d = ERR_GBAR_TO_SPUR; err_wid_d = spur_wid;           err_bar_d = spur_bar;
    end
    if (clear) begin
      err_status_d = err_det;
      err_count_d  = err_valid_d ? 8'd1 : 8'd0;
    end else begin
      err_status_d = err_status_q | err_det;
      err_count_d  = (err_valid_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_valid_q  <= 1'b0;
      err_code_q   <= ERR_STALL_TO;
      err_wid_q    <= '0;
      err_bar_q    <= '0;
      err_status_q <= '0;
      err_count_q  <= '0;
    end else begin
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      err_wid_q    <= err_wid_d;
      err_bar_q    <= err_bar_d;
      err_status_q <= err_status_d;
      err_count_q  <= err_count_d;
    end
  end

  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign err_wid    = err_wid_q;
  assign err_bar    = err_bar_q;
  assign err_status = err_status_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_vx_sched_checker.sv
// Self-checking bench for vx_sched_checker: vector table, directed corner
// sequences, and randomized traffic against a behavioural reference model.
module tb_vx_sched_checker;

  localparam int NW = 4;
  localparam int NB = 4;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [TW-1:0] cfg_timeout;
  logic          clear, ctl_valid, bar_valid, bar_is_global, bar_is_noop, wspawn_valid;
  logic [1:0]    ctl_wid, bar_id, bar_size_m1, gbar_req_id, gbar_rsp_id;
  logic [NW-1:0] active_warps, stalled_warps;
  logic          gbar_req_valid, gbar_rsp_valid;
  logic          err_valid;
  logic [2:0]    err_code;
  logic [1:0]    err_wid, err_bar;
  logic [7:0]    err_status, err_count;

  vx_sched_checker dut (
    .clk(clk), .reset(reset), .cfg_timeout(cfg_timeout), .clear(clear),
    .ctl_valid(ctl_valid), .ctl_wid(ctl_wid), .bar_valid(bar_valid),
    .bar_is_global(bar_is_global), .bar_is_noop(bar_is_noop), .bar_id(bar_id),
    .bar_size_m1(bar_size_m1), .wspawn_valid(wspawn_valid),
    .active_warps(active_warps), .stalled_warps(stalled_warps),
    .gbar_req_valid(gbar_req_valid), .gbar_rsp_valid(gbar_rsp_valid),
    .gbar_req_id(gbar_req_id), .gbar_rsp_id(gbar_rsp_id),
    .err_valid(err_valid), .err_code(err_code), .err_wid(err_wid), .err_bar(err_bar),
    .err_status(err_status), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int  m_scnt [NW];
  bit  m_mask [NB][NW];
  int  m_cnt  [NB];
  int  m_size [NB];
  int  m_gst, m_gid, m_gwid, m_gtim;
  bit  e_valid;
  int  e_code, e_wid, e_bar, e_status, e_count;

  typedef struct {
    bit         cv;
    bit         ws;
    logic [3:0] act;
    bit         rv;
    logic [1:0] rid;
    bit         ev;
    int         ec;
    int         eb;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int w = 0; w < NW; w++) m_scnt[w] = 0;
    for (int b = 0; b < NB; b++) begin
      m_cnt[b]  = 0;
      m_size[b] = 0;
      for (int w = 0; w < NW; w++) m_mask[b][w] = 1'b0;
    end
    m_gst = 0; m_gid = 0; m_gwid = 0; m_gtim = 0;
    e_valid = 1'b0; e_code = 0; e_wid = 0; e_bar = 0; e_status = 0; e_count = 0;
  endfunction

  function automatic void model_step();
    bit det [8];
    int cw [8];
    int cb [8];
    int t, ab, aw, target, rel_b;
    bit arr, any;
    t = int'(cfg_timeout);
    for (int c = 0; c < 8; c++) begin det[c] = 1'b0; cw[c] = 0; cb[c] = 0; end
    // stall watchdogs
    for (int w = 0; w < NW; w++) begin
      if (stalled_warps[w]) begin
        if (m_scnt[w] < t) begin
          m_scnt[w]++;
          if (m_scnt[w] == t && !det[0]) begin det[0] = 1'b1; cw[0] = w; end
        end
      end else m_scnt[w] = 0;
    end
    // local barrier arrival decision
    arr = ctl_valid && bar_valid && !bar_is_global;
    ab = int'(bar_id); aw = int'(ctl_wid); rel_b = -1;
    if (arr) begin
      if (m_cnt[ab] != 0 && int'(bar_size_m1) != m_size[ab]) begin det[2] = 1'b1; cw[2] = aw; cb[2] = ab; end
      if (m_mask[ab][aw]) begin
        det[1] = 1'b1; cw[1] = aw; cb[1] = ab;
      end else begin
        target = (m_cnt[ab] == 0) ? int'(bar_size_m1) : m_size[ab];
        if (m_cnt[ab] + 1 == target + 1) rel_b = ab;
      end
    end
    // escapes from the pre-edge masks
    for (int b = 0; b < NB && !det[3]; b++) begin
      if (b != rel_b) begin
        for (int w = 0; w < NW; w++) begin
          if (m_mask[b][w] && !stalled_warps[w] && !det[3]) begin det[3] = 1'b1; cb[3] = b; cw[3] = w; end
        end
      end
    end
    if (arr && !m_mask[ab][aw]) begin
      if (rel_b == ab) begin
        for (int w = 0; w < NW; w++) m_mask[ab][w] = 1'b0;
        m_cnt[ab] = 0;
      end else begin
        if (m_cnt[ab] == 0) m_size[ab] = int'(bar_size_m1);
        m_mask[ab][aw] = 1'b1;
        m_cnt[ab]++;
      end
    end
    if (ctl_valid && wspawn_valid && $countones(active_warps) != 1) begin det[4] = 1'b1; cw[4] = aw; end
    // global barrier pairing
    case (m_gst)
      0: begin
        if (gbar_rsp_valid) begin det[7] = 1'b1; cb[7] = int'(gbar_rsp_id); cw[7] = 0; end
        if (ctl_valid && bar_valid && bar_is_global && bar_is_noop) begin
          m_gst = 1; m_gid = int'(bar_id); m_gwid = aw;
        end
      end
      1: begin
        if (gbar_rsp_valid) begin det[7] = 1'b1; cb[7] = int'(gbar_rsp_id); cw[7] = 0; end
        if (gbar_req_valid) begin m_gst = 2; m_gtim = 0; end
        else begin det[5] = 1'b1; cw[5] = m_gwid; cb[5] = m_gid; m_gst = 0; end
      end
      default: begin
        if (gbar_rsp_valid) begin
          if (int'(gbar_rsp_id) != m_gid) begin det[6] = 1'b1; cw[6] = m_gwid; cb[6] = m_gid; end
          m_gst = 0;
        end else if (t != 0) begin
          m_gtim++;
          if (m_gtim >= t) begin det[7] = 1'b1; cw[7] = m_gwid; cb[7] = m_gid; m_gst = 0; end
        end
      end
    endcase
    if (clear) begin e_status = 0; e_count = 0; end
    any = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (det[c]) begin
        if (!any) begin e_code = c; e_wid = cw[c]; e_bar = cb[c]; end
        any = 1'b1;
        e_status = e_status | (1 << c);
      end
    end
    e_valid = any;
    if (any && e_count < 255) e_count++;
  endfunction

  task automatic idle();
    clear = 0; ctl_valid = 0; ctl_wid = 0; bar_valid = 0; bar_is_global = 0; bar_is_noop = 0;
    bar_id = 0; bar_size_m1 = 0; wspawn_valid = 0; active_warps = 4'b0001;
    gbar_req_valid = 0; gbar_rsp_valid = 0; gbar_req_id = 0; gbar_rsp_id = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
    chk("err_valid",  err_valid,  e_valid);
    chk("err_code",   err_code,   e_code);
    chk("err_wid",    err_wid,    e_wid);
    chk("err_bar",    err_bar,    e_bar);
    chk("err_status", err_status, e_status);
    chk("err_count",  err_count,  e_count);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    stalled_warps = '0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_valid",  err_valid,  0);
    chk("rst_code",   err_code,   0);
    chk("rst_wid",    err_wid,    0);
    chk("rst_bar",    err_bar,    0);
    chk("rst_status", err_status, 0);
    chk("rst_count",  err_count,  0);
    reset = 1'b0;
  endtask

  task automatic arrive(input int b, input int w, input int sz);
    ctl_valid = 1; bar_valid = 1; bar_is_global = 0;
    bar_id = 2'(b); ctl_wid = 2'(w); bar_size_m1 = 2'(sz);
  endtask

  task automatic gnoop(input int b);
    ctl_valid = 1; bar_valid = 1; bar_is_global = 1; bar_is_noop = 1; bar_id = 2'(b); ctl_wid = 2'd1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int pulses, pulse_at, errs, n;
    tbl[0] = '{1'b1, 1'b1, 4'b0011, 1'b0, 2'd0, 1'b1, 4, 0};
    tbl[1] = '{1'b1, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 0, 0};
    tbl[2] = '{1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 4, 0};
    tbl[3] = '{1'b0, 1'b1, 4'b0011, 1'b0, 2'd0, 1'b0, 0, 0};
    tbl[4] = '{1'b1, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b1, 4, 0};
    tbl[5] = '{1'b1, 1'b0, 4'b0110, 1'b0, 2'd0, 1'b0, 0, 0};
    tbl[6] = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 7, 3};
    tbl[7] = '{1'b1, 1'b1, 4'b0101, 1'b1, 2'd2, 1'b1, 4, 0};
    tbl[8] = '{1'b1, 1'b1, 4'b1000, 1'b1, 2'd1, 1'b1, 7, 1};

    cfg_timeout = '0;
    do_reset();

    // single-cycle vector table
    foreach (tbl[i]) begin
      idle();
      ctl_valid = tbl[i].cv; wspawn_valid = tbl[i].ws; active_warps = tbl[i].act;
      gbar_rsp_valid = tbl[i].rv; gbar_rsp_id = tbl[i].rid;
      step();
      chk("tbl_valid", err_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl_code", err_code, tbl[i].ec);
        chk("tbl_bar",  err_bar,  tbl[i].eb);
      end
      idle();
      step();
    end

    // stall watchdog: warp 2 stalled 10 cycles, limit 8
    do_reset();
    cfg_timeout = 16'd8;
    stalled_warps = 4'b0100;
    pulses = 0; pulse_at = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (err_valid) begin
        pulses++; pulse_at = i;
        chk("stall_code", err_code, 0);
        chk("stall_wid",  err_wid,  2);
      end
    end
    stalled_warps = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (err_valid) pulses++;
    end
    chk("stall_pulses", pulses, 1);
    chk("stall_at", pulse_at, 8);

    // full barrier release: four warps on bar 1, then everyone unstalls
    do_reset();
    cfg_timeout = '0;
    errs = 0;
    for (int w = 0; w < 4; w++) begin
      arrive(1, w, 3);
      stalled_warps[w] = 1'b1;
      step();
      errs += int'(err_valid);
    end
    idle();
    stalled_warps = '0;
    step();
    errs += int'(err_valid);
    chk("bar_release_errs", errs, 0);

    // duplicate arrival then escape
    do_reset();
    stalled_warps = 4'b0010;
    arrive(0, 1, 3);
    step();
    chk("dup_first_valid", err_valid, 0);
    step();
    chk("dup_valid", err_valid, 1);
    chk("dup_code",  err_code,  1);
    chk("dup_bar",   err_bar,   0);
    chk("dup_wid",   err_wid,   1);
    idle();
    stalled_warps = '0;
    step();
    chk("esc_valid", err_valid, 1);
    chk("esc_code",  err_code,  3);
    chk("esc_wid",   err_wid,   1);
    chk("esc_bar",   err_bar,   0);

    // size mismatch on bar 3 (still counted)
    do_reset();
    stalled_warps = 4'b1111;
    arrive(3, 0, 2);
    step();
    arrive(3, 2, 1);
    step();
    chk("size_code", err_code, 2);
    chk("size_wid",  err_wid,  2);
    chk("size_bar",  err_bar,  3);
    idle();
    step();

    // global barrier: wrong response id, then response timeout, then missing request
    do_reset();
    gnoop(2);
    step();
    idle(); gbar_req_valid = 1; gbar_req_id = 2;
    step();
    idle(); gbar_rsp_valid = 1; gbar_rsp_id = 3;
    step();
    chk("gid_valid", err_valid, 1);
    chk("gid_code",  err_code,  6);
    chk("gid_bar",   err_bar,   2);
    idle();
    cfg_timeout = 16'd5;
    gnoop(2);
    step();
    idle(); gbar_req_valid = 1; gbar_req_id = 2;
    step();
    idle();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (err_valid) break;
    end
    chk("gto_code",   err_code, 7);
    chk("gto_bar",    err_bar,  2);
    chk("gto_cycles", n,        5);
    gnoop(1);
    step();
    idle();
    step();
    chk("noreq_code", err_code, 5);
    chk("noreq_bar",  err_bar,  1);

    // simultaneous STALL_TO and WSPAWN
    do_reset();
    cfg_timeout = 16'd3;
    stalled_warps = 4'b0001;
    step();
    step();
    ctl_valid = 1; wspawn_valid = 1; active_warps = 4'b0011; ctl_wid = 2'd3;
    step();
    chk("both_code",   err_code,   0);
    chk("both_status", err_status, 8'h11);
    chk("both_count",  err_count,  1);

    // clear together with a new error
    stalled_warps = '0;
    clear = 1;
    step();
    chk("clr_status", err_status, 8'h10);
    chk("clr_count",  err_count,  1);
    clear = 0;
    step();
    chk("clr_count2", err_count, 2);

    // count saturation
    for (int i = 0; i < 260; i++) step();
    chk("sat_count", err_count, 255);
    idle();
    clear = 1;
    step();
    chk("clr_only_count", err_count, 0);
    clear = 0;

    // randomized traffic against the model, with a mid-run reset
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) begin
        if ($urandom_range(0, 5) == 0) cfg_timeout = '0;
        else cfg_timeout = 16'($urandom_range(2, 12));
      end
      if (cyc == 1500) do_reset();
      ctl_valid      = 1'($urandom_range(0, 1));
      ctl_wid        = 2'($urandom_range(0, 3));
      bar_valid      = ($urandom_range(0, 9) < 4);
      bar_is_global  = ($urandom_range(0, 3) == 0);
      bar_is_noop    = 1'($urandom_range(0, 1));
      bar_id         = 2'($urandom_range(0, 3));
      bar_size_m1    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd3;
      wspawn_valid   = ($urandom_range(0, 9) == 0);
      active_warps   = 4'($urandom_range(0, 15));
      gbar_req_valid = ($urandom_range(0, 9) < 3);
      gbar_req_id    = 2'($urandom_range(0, 3));
      gbar_rsp_valid = ($urandom_range(0, 9) == 0);
      gbar_rsp_id    = 2'($urandom_range(0, 3));
      clear          = ($urandom_range(0, 49) == 0);
      for (int w = 0; w < NW; w++) begin
        if ($urandom_range(0, 9) == 0) stalled_warps[w] = ~stalled_warps[w];
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
